// File: rtl/shift_pkg.sv
// Shared types for the iterative shifter: operation codes and FSM state encodings.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// One cycle's shift of the accumulator by 0..STEP bits as log2(STEP)+1 mux levels.
// Rotate support is present only when ITER_SHIFTER_ROTATE_EN is defined; otherwise ROR acts as SRL.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 8,
  parameter int unsigned KW    = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [KW-1:0]    k_i,
  input  shift_op_e        mode_i,
  output logic [WIDTH-1:0] res_o
);

  logic [WIDTH-1:0] stage [0:KW];

  assign stage[0] = acc_i;

  // Level g conditionally shifts by 2**g; arithmetic fill composes because each
  // level replicates the sign bit of its own input.
  for (genvar g = 0; g < KW; g++) begin : g_lvl
    localparam int unsigned S = 1 << g;
    logic [WIDTH-1:0] sh;

    always_comb begin
      sh = stage[g];
      case (mode_i)
        OP_SLL:  sh = stage[g] << S;
        OP_SRL:  sh = stage[g] >> S;
        OP_SRA:  sh = $signed(stage[g]) >>> S;
`ifdef ITER_SHIFTER_ROTATE_EN
        OP_ROR:  sh = (stage[g] >> S) | (stage[g] << (WIDTH - S));
`else
        OP_ROR:  sh = stage[g] >> S;
`endif
        default: sh = stage[g];
      endcase
    end

    assign stage[g+1] = k_i[g] ? sh : stage[g];
  end

  assign res_o = stage[KW];

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: at most STEP bits per clock under a start/ready/done handshake.
// Define ITER_SHIFTER_ROTATE_EN to make op=11 a rotate-right; otherwise it behaves as SRL.
module iter_shifter
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result
);

  localparam int unsigned RW = $clog2(WIDTH);
  localparam int unsigned KW = $clog2(STEP) + 1;
  localparam logic [RW:0] STEP_W = (RW + 1)'(STEP);

  shift_state_e     state_q, state_d;
  logic [WIDTH-1:0] acc_q;
  logic [RW-1:0]    rem_q, rem_d;
  shift_op_e        mode_q;

  logic             accept;
  logic             last_step;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] step_res;

  assign accept = start & ready;

  // STEP may equal WIDTH, which rem cannot represent, so compare one bit wider.
  assign last_step = ({1'b0, rem_q} <= STEP_W);
  assign k         = last_step ? KW'(rem_q) : KW'(STEP);
  assign rem_d     = rem_q - RW'(k);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .acc_i  (acc_q),
    .k_i    (k),
    .mode_i (mode_q),
    .res_o  (step_res)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (last_step) state_d = ST_DONE;
      ST_DONE:  state_d = accept ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      ST_IDLE:  ready = 1'b1;
      ST_SHIFT: busy  = 1'b1;
      ST_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      rem_q  <= '0;
      mode_q <= OP_SLL;
    end else if (accept) begin
      acc_q  <= data_in;
      rem_q  <= shamt;
      mode_q <= shift_op_e'(op);
    end else if (state_q == ST_SHIFT) begin
      acc_q  <= step_res;
      rem_q  <= rem_d;
    end
  end

  assign result = acc_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter (WIDTH=32, STEP=8): directed cases plus random ops
// against an arithmetic reference model; honours ITER_SHIFTER_ROTATE_EN for op=11.
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        ready, busy, done;
  logic [31:0] result;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  iter_shifter #(
    .WIDTH (32),
    .STEP  (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .data_in (data_in),
    .shamt   (shamt),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d,
                                        input int unsigned s);
    logic [63:0] dd;
    dd = '0;
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return $signed(d) >>> s;
      default: begin
`ifdef ITER_SHIFTER_ROTATE_EN
        dd = {d, d} >> s;
        return dd[31:0];
`else
        return d >> s;
`endif
      end
    endcase
  endfunction

  function automatic int unsigned cycles(input int unsigned s);
    return (s == 0) ? 1 : (s + 7) / 8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the unit ready; returns one negedge after the accept edge.
  task automatic drive(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
    start   = 1'b1;
    op      = o;
    data_in = d;
    shamt   = s;
    @(negedge clk);
    start   = 1'b0;
    op      = 2'($urandom);
    data_in = $urandom;
    shamt   = 5'($urandom);
  endtask

  // Counts busy cycles (bounded) and checks the done cycle.
  task automatic finish_op(input string tag, input logic [31:0] exp, input int unsigned n_exp);
    int unsigned n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, n, n_exp);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_ready_in_done"}, {31'b0, ready}, 32'd1);
    chk({tag, "_result"}, result, exp);
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                       input logic [4:0] s);
    logic [31:0] exp;
    exp = model(o, d, s);
    @(negedge clk);
    drive(o, d, s);
    finish_op(tag, exp, cycles(s));
    @(negedge clk);
    chk({tag, "_done_pulse_ends"}, {31'b0, done}, 32'd0);
    chk({tag, "_result_held"}, result, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    data_in = '0;
    shamt   = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready",  {31'b0, ready}, 32'd1);
    chk("rst_busy",   {31'b0, busy},  32'd0);
    chk("rst_done",   {31'b0, done},  32'd0);
    chk("rst_result", result, 32'h0);
    reset_n = 1'b1;

    do_op("sll_1_by_2",   2'b00, 32'h0000_0001, 5'd2);
    chk("sll_1_by_2_const", result, 32'h0000_0004);
    do_op("sra_msb_by_31", 2'b10, 32'h8000_0000, 5'd31);
    chk("sra_msb_by_31_const", result, 32'hFFFF_FFFF);
    do_op("srl_msb_by_31", 2'b01, 32'h8000_0000, 5'd31);
    chk("srl_msb_by_31_const", result, 32'h0000_0001);
    do_op("srl_by_0",  2'b01, 32'hDEAD_BEEF, 5'd0);
    do_op("sll_by_8",  2'b00, 32'h1234_5678, 5'd8);
    do_op("sra_by_9",  2'b10, 32'h9234_5678, 5'd9);
    do_op("ror_1_by_1", 2'b11, 32'h0000_0001, 5'd1);
`ifdef ITER_SHIFTER_ROTATE_EN
    chk("ror_1_by_1_const", result, 32'h8000_0000);
`else
    chk("ror_1_by_1_const", result, 32'h0000_0000);
`endif

    // Back-to-back: second start issued during the first op's done cycle.
    @(negedge clk);
    drive(2'b00, 32'h0000_00FF, 5'd12);
    finish_op("b2b_a", model(2'b00, 32'h0000_00FF, 12), 2);
    drive(2'b10, 32'hF000_000F, 5'd20);
    chk("b2b_no_gap_busy", {31'b0, busy}, 32'd1);
    finish_op("b2b_b", model(2'b10, 32'hF000_000F, 20), 3);
    @(negedge clk);

    // Start pulsed while busy must be ignored.
    drive(2'b01, 32'hCAFE_F00D, 5'd31);
    start   = 1'b1;
    op      = 2'b00;
    data_in = 32'hFFFF_FFFF;
    shamt   = 5'd1;
    @(negedge clk);
    start   = 1'b0;
    finish_op("ignored_start", model(2'b01, 32'hCAFE_F00D, 31), 3);
    @(negedge clk);

    // Reset asserted mid-operation aborts it.
    drive(2'b10, 32'h8765_4321, 5'd31);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_ready",  {31'b0, ready}, 32'd1);
    chk("midrst_busy",   {31'b0, busy},  32'd0);
    chk("midrst_done",   {31'b0, done},  32'd0);
    chk("midrst_result", result, 32'h0);
    repeat (2) @(negedge clk);
    chk("midrst_no_done", {31'b0, done}, 32'd0);
    reset_n = 1'b1;
    do_op("after_reset", 2'b00, 32'h0F0F_0F0F, 5'd17);

    for (int i = 0; i < 40; i++) begin
      do_op($sformatf("rand%0d", i), 2'($urandom), $urandom, 5'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    failed++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "timeout");
  end

endmodule
